// File: rtl/pixel_buf_writer.sv
// pixel_buf_writer
//   Fill stage for a dual-port pixel SRAM (LANES x PIX_W per word,
//   active-low per-lane write enables). It accepts a valid/ready pixel
//   stream, maps pixel k to word base+k/LANES and lane k%LANES, and
//   drives SRAM port A. The stream stalls whenever the word about to be
//   written equals the word port B will read next cycle, because the
//   SRAM wrapper remaps port A in that case and would corrupt the write.
//
// Optional build macro: PIXEL_WR_PACK_EN
//   Defined   - pixels gather in a pack register; one write per word
//               (the final partial word enables only its filled lanes).
//   Undefined - one single-lane write per accepted pixel.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle job start pulse (sampled in IDLE only)
//   base_addr          first SRAM word of the job
//   pix_count          number of pixels in the job
//   in_valid/in_ready  pixel stream handshake, in_pixel = data
//   rd_oe_nxt          port-B reader asserts OEB next cycle
//   rd_addr_nxt        port-B address presented next cycle
//   sram_a/dia/wean    registered port-A address, data, lane enables
//   sram_oea           port-A output enable, tied low
//   busy               job in progress
//   done               one-cycle pulse after the last write is issued
module pixel_buf_writer #(
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 16,
    parameter int LANES  = 3,
    parameter int CNT_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        pix_count,
    input  logic                    in_valid,
    input  logic [PIX_W-1:0]        in_pixel,
    output logic                    in_ready,
    input  logic                    rd_oe_nxt,
    input  logic [ADDR_W-1:0]       rd_addr_nxt,
    output logic [ADDR_W-1:0]       sram_a,
    output logic [LANES*PIX_W-1:0]  sram_dia,
    output logic [LANES-1:0]        sram_wean,
    output logic                    sram_oea,
    output logic                    busy,
    output logic                    done
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DATA_W = LANES * PIX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

`ifdef PIXEL_WR_PACK_EN
    // Active-low enables for lanes 0..lane (a possibly partial word).
    function automatic logic [LANES-1:0] fill_wean(input logic [LANE_W-1:0] lane);
        logic [LANES-1:0] w;
        w = '1;
        for (int i = 0; i < LANES; i++) begin
            if (i <= int'(lane)) begin
                w[i] = 1'b0;
            end
        end
        return w;
    endfunction
`else
    // Active-low enable for exactly one lane.
    function automatic logic [LANES-1:0] lane_wean(input logic [LANE_W-1:0] lane);
        logic [LANES-1:0] w;
        w = '1;
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(lane)) begin
                w[i] = 1'b0;
            end
        end
        return w;
    endfunction
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
    logic [DATA_W-1:0]   sram_dia_q, sram_dia_d;
    logic [LANES-1:0]    sram_wean_q, sram_wean_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef PIXEL_WR_PACK_EN
    logic [DATA_W-1:0]   pack_q, pack_d;
`endif

    logic collide_s;
    logic last_lane_s;
    logic last_pix_s;
    logic issue_s;
    logic ready_s;
    logic accept_s;

    // waddr is exactly the address that would be registered on accept,
    // so comparing it with next cycle's port-B address covers the write.
    assign collide_s   = rd_oe_nxt && (rd_addr_nxt == waddr_q);
    assign last_lane_s = (lane_q == LANE_W'(LANES - 1));
    assign last_pix_s  = (remaining_q == CNT_W'(1));
`ifdef PIXEL_WR_PACK_EN
    // Only the word-issue accept touches port A; filling lanes never stalls.
    assign issue_s     = last_lane_s || last_pix_s;
`else
    assign issue_s     = 1'b1;
`endif
    assign ready_s     = (state_q == S_RUN) && !(issue_s && collide_s);
    assign accept_s    = in_valid && ready_s;

    // Next-state logic for the FSM, job counters and port-A outputs.
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        sram_a_d    = sram_a_q;
        sram_dia_d  = sram_dia_q;
        sram_wean_d = '1;
`ifdef PIXEL_WR_PACK_EN
        pack_d      = pack_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    waddr_d     = base_addr;
                    remaining_d = pix_count;
                    lane_d      = '0;
                    state_d     = (pix_count == '0) ? S_FIN : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s) begin
`ifdef PIXEL_WR_PACK_EN
                    pack_d[int'(lane_q)*PIX_W +: PIX_W] = in_pixel;
                    if (issue_s) begin
                        sram_a_d    = waddr_q;
                        sram_dia_d  = pack_d;
                        sram_wean_d = fill_wean(lane_q);
                        pack_d      = '0;
                    end else begin
                        sram_wean_d = '1;
                    end
`else
                    sram_a_d    = waddr_q;
                    sram_dia_d  = '0;
                    sram_dia_d[int'(lane_q)*PIX_W +: PIX_W] = in_pixel;
                    sram_wean_d = lane_wean(lane_q);
`endif
                    remaining_d = remaining_q - CNT_W'(1);
                    if (last_lane_s) begin
                        lane_d  = '0;
                        waddr_d = waddr_q + ADDR_W'(1);  // wraps at 2^ADDR_W
                    end else begin
                        lane_d  = lane_q + LANE_W'(1);
                    end
                    if (last_pix_s) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_q == S_FIN);
    end

    // State, counters and registered port-A outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            remaining_q <= '0;
            lane_q      <= '0;
            sram_a_q    <= '0;
            sram_dia_q  <= '0;
            sram_wean_q <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PIXEL_WR_PACK_EN
            pack_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            sram_a_q    <= sram_a_d;
            sram_dia_q  <= sram_dia_d;
            sram_wean_q <= sram_wean_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PIXEL_WR_PACK_EN
            pack_q      <= pack_d;
`endif
        end
    end

    assign in_ready  = ready_s;
    assign sram_a    = sram_a_q;
    assign sram_dia  = sram_dia_q;
    assign sram_wean = sram_wean_q;
    assign sram_oea  = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_buf_writer.sv
module tb_pixel_buf_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [11:0] pix_count;
    logic        in_valid;
    logic [15:0] in_pixel;
    logic        in_ready;
    logic        rd_oe_nxt;
    logic [9:0]  rd_addr_nxt;
    logic [9:0]  sram_a;
    logic [47:0] sram_dia;
    logic [2:0]  sram_wean;
    logic        sram_oea;
    logic        busy;
    logic        done;

    pixel_buf_writer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .pix_count(pix_count), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready), .rd_oe_nxt(rd_oe_nxt), .rd_addr_nxt(rd_addr_nxt),
        .sram_a(sram_a), .sram_dia(sram_dia), .sram_wean(sram_wean),
        .sram_oea(sram_oea), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc = -1;
    int start_cyc = 0;
    int ready_low = 0;

    // log of observed port-A writes
    logic [9:0]  log_a[$];
    logic [2:0]  log_w[$];
    logic [47:0] log_d[$];
    int          log_c[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pix(input logic [9:0] b, input int k);
        return 16'h8000 + {2'b00, b, 4'h0} + 16'(k);
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 streaming, 2 finishing
    int          m_ph = 0;
    int          m_base = 0;
    int          m_cnt = 0;
    int          m_k = 0;
    logic [15:0] m_pk[3];
    logic [2:0]  exp_wean = 3'b111;
    logic [9:0]  exp_a = 10'd0;
    logic [47:0] exp_d = 48'd0;
    logic        exp_done = 1'b0;

    always @(negedge clk) begin
        int   waddr;
        int   lane;
        logic coll;
        logic issue;
        logic exp_rdy;
        if (rst) begin
            chk("rst_wean", 64'(sram_wean), 64'(3'b111));
            chk("rst_a", 64'(sram_a), 64'd0);
            chk("rst_dia", 64'(sram_dia), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_ready", 64'(in_ready), 64'd0);
            m_ph = 0; m_k = 0; m_cnt = 0;
            exp_wean = 3'b111; exp_done = 1'b0;
            for (int i = 0; i < 3; i++) m_pk[i] = 16'd0;
        end else begin
            chk("wean", 64'(sram_wean), 64'(exp_wean));
            if (exp_wean != 3'b111) begin
                chk("addr", 64'(sram_a), 64'(exp_a));
                chk("data", 64'(sram_dia), 64'(exp_d));
            end
            if (sram_wean != 3'b111) begin
                log_a.push_back(sram_a); log_w.push_back(sram_wean);
                log_d.push_back(sram_dia); log_c.push_back(cyc);
            end
            chk("done", 64'(done), 64'(exp_done));
            if (done) done_cyc = cyc;
            chk("busy", 64'(busy), 64'(m_ph == 1));
            chk("oea", 64'(sram_oea), 64'd0);
            waddr = (m_base + m_k / 3) % 1024;
            lane  = m_k % 3;
            coll  = rd_oe_nxt && (rd_addr_nxt == 10'(waddr));
`ifdef PIXEL_WR_PACK_EN
            issue = (lane == 2) || (m_k == m_cnt - 1);
`else
            issue = 1'b1;
`endif
            exp_rdy = (m_ph == 1) && !(issue && coll);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            exp_wean = 3'b111;
            exp_done = (m_ph == 2);
            case (m_ph)
                0: if (start) begin
                    m_base = int'(base_addr); m_cnt = int'(pix_count); m_k = 0;
                    for (int i = 0; i < 3; i++) m_pk[i] = 16'd0;
                    m_ph = (pix_count == 12'd0) ? 2 : 1;
                end
                1: if (in_valid && exp_rdy) begin
                    exp_a = 10'(waddr);
`ifdef PIXEL_WR_PACK_EN
                    m_pk[lane] = in_pixel;
                    if (issue) begin
                        exp_d = {(lane >= 2) ? m_pk[2] : 16'd0,
                                 (lane >= 1) ? m_pk[1] : 16'd0, m_pk[0]};
                        exp_wean = (lane == 2) ? 3'b000 : (lane == 1) ? 3'b100 : 3'b110;
                        for (int i = 0; i < 3; i++) m_pk[i] = 16'd0;
                    end
`else
                    exp_d = 48'd0;
                    exp_d[lane*16 +: 16] = in_pixel;
                    exp_wean = 3'b111 ^ (3'b001 << lane);
`endif
                    m_k++;
                    if (m_k == m_cnt) m_ph = 2;
                end
                default: m_ph = 0;
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    // Called #1 after a rising edge. coll_at: accepted-pixel count at which
    // port B targets the write word for 3 cycles. abort_at: assert rst then.
    task automatic run_job(input logic [9:0] b, input int n, input int coll_at,
                           input int abort_at);
        int acc = 0;
        int guard = 0;
        int coll_left = 3;
        bit acc_now;
        bit in_coll;
        log_a.delete(); log_w.delete(); log_d.delete(); log_c.delete();
        done_cyc = -1; ready_low = 0;
        base_addr = b; pix_count = 12'(n); start = 1'b1; start_cyc = cyc;
        rd_oe_nxt = 1'b1; rd_addr_nxt = b + 10'd5;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = (n != 0); in_pixel = pix(b, 0);
        while (guard < 200 && done_cyc < 0) begin
            rd_oe_nxt = 1'b1; rd_addr_nxt = b + 10'd5; in_coll = 1'b0;
            if (acc == coll_at && coll_left > 0) begin
                rd_addr_nxt = b + 10'(acc / 3); coll_left--; in_coll = 1'b1;
            end
            @(negedge clk);
            acc_now = in_valid && in_ready;
            if (in_coll && !in_ready) ready_low++;
            @(posedge clk); #1;
            if (acc_now) begin
                acc++;
                if (acc >= n) in_valid = 1'b0;
                else in_pixel = pix(b, acc);
            end
            if (abort_at > 0 && acc == abort_at) begin
                rst = 1'b1; #1;
                chk("abort_wean", 64'(sram_wean), 64'(3'b111));
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_ready", 64'(in_ready), 64'd0);
                chk("abort_a", 64'(sram_a), 64'd0);
                @(negedge clk); @(posedge clk); #1;
                rst = 1'b0; in_valid = 1'b0;
                return;
            end
            guard++;
        end
        chk("job_done_seen", 64'(done_cyc >= 0), 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 10'd0; pix_count = 12'd0;
        in_valid = 1'b0; in_pixel = 16'd0; rd_oe_nxt = 1'b0; rd_addr_nxt = 10'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
`ifdef PIXEL_WR_PACK_EN
        begin
            run_job(10'h000, 5, -1, -1);
            chk("pk_nwr", 64'(log_a.size()), 64'd2);
            if (log_a.size() == 2) begin
                chk("pk_a0", 64'(log_a[0]), 64'h000);
                chk("pk_w0", 64'(log_w[0]), 64'(3'b000));
                chk("pk_d0", 64'(log_d[0]), 64'h8002_8001_8000);
                chk("pk_a1", 64'(log_a[1]), 64'h001);
                chk("pk_w1", 64'(log_w[1]), 64'(3'b100));
                chk("pk_d1", 64'(log_d[1]), 64'h0000_8004_8003);
            end
            run_job(10'h020, 6, 2, -1);
            chk("pk_coll_nwr", 64'(log_a.size()), 64'd2);
        end
`else
        begin
            logic [9:0] t1a[7] = '{10'h010, 10'h010, 10'h010, 10'h011, 10'h011, 10'h011, 10'h012};
            logic [2:0] t1w[7] = '{3'b110, 3'b101, 3'b011, 3'b110, 3'b101, 3'b011, 3'b110};
            logic [9:0] t2a[4] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h000};
            // T1: base 0x010, 7 pixels
            run_job(10'h010, 7, -1, -1);
            chk("t1_nwr", 64'(log_a.size()), 64'd7);
            if (log_a.size() == 7) begin
                for (int i = 0; i < 7; i++) begin
                    chk("t1_addr", 64'(log_a[i]), 64'(t1a[i]));
                    chk("t1_wean", 64'(log_w[i]), 64'(t1w[i]));
                end
                chk("t1_d6", 64'(log_d[6]), 64'h0000_0000_8106);
                chk("t1_done_cyc", 64'(done_cyc), 64'(log_c[6] + 1));
            end
            @(negedge clk);
            chk("t1_busy_after", 64'(busy), 64'd0);
            @(posedge clk); #1;
            // T2: wrap at top of memory
            run_job(10'h3FF, 4, -1, -1);
            chk("t2_nwr", 64'(log_a.size()), 64'd4);
            if (log_a.size() == 4) begin
                for (int i = 0; i < 4; i++) chk("t2_addr", 64'(log_a[i]), 64'(t2a[i]));
                chk("t2_w3", 64'(log_w[3]), 64'(3'b110));
                chk("t2_d3", 64'(log_d[3]), 64'h0000_0000_BFF3);
            end
            // T3: empty job
            run_job(10'h100, 0, -1, -1);
            chk("t3_nwr", 64'(log_a.size()), 64'd0);
            chk("t3_done_cyc", 64'(done_cyc), 64'(start_cyc + 2));
            // T4: port-B collision for 3 cycles after 2 pixels
            run_job(10'h020, 6, 2, -1);
            chk("t4_ready_low", 64'(ready_low), 64'd3);
            chk("t4_nwr", 64'(log_a.size()), 64'd6);
            if (log_a.size() == 6) begin
                chk("t4_a2", 64'(log_a[2]), 64'h020);
                chk("t4_w2", 64'(log_w[2]), 64'(3'b011));
                chk("t4_d2", 64'(log_d[2]), 64'h8202_0000_0000);
                chk("t4_d3", 64'(log_d[3]), 64'h0000_0000_8203);
                chk("t4_gap", 64'(log_c[2] - log_c[1]), 64'd4);
            end
            // T5: async reset mid-job, then clean restart
            run_job(10'h040, 6, -1, 2);
            @(posedge clk); #1;
            run_job(10'h050, 3, -1, -1);
            chk("t5_nwr", 64'(log_a.size()), 64'd3);
            if (log_a.size() == 3) begin
                chk("t5_a0", 64'(log_a[0]), 64'h050);
                chk("t5_a2", 64'(log_a[2]), 64'h050);
                chk("t5_w0", 64'(log_w[0]), 64'(3'b110));
                chk("t5_w1", 64'(log_w[1]), 64'(3'b101));
                chk("t5_w2", 64'(log_w[2]), 64'(3'b011));
                chk("t5_d1", 64'(log_d[1]), 64'h0000_8501_0000);
            end
        end
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_buf_writer.md
Name: pixel_buf_writer

Overview:
- Upstream fill stage for the 1024x48 dual-port pixel SRAM (3 lanes x 16 bit, active-low per-lane write enables).
- Accepts a valid/ready stream of 16-bit pixels, maps pixel k to word base+k/3, lane k%3, and drives SRAM port A.
- Stalls the stream when its next write would collide with a port-B read.
  - The SRAM wrapper remaps port A when A==B and OEB=1, which would corrupt the write.

Parameters:
- ADDR_W, 10, SRAM word address width (depth 2^ADDR_W).
- PIX_W, 16, pixel / lane width.
- LANES, 3, lanes per SRAM word (data width LANES*PIX_W).
- CNT_W, 12, pixel-count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a fill job (sampled only in IDLE).
- base_addr  in  ADDR_W  first SRAM word of the job.
- pix_count  in  CNT_W  pixels in the job.
- in_valid  in  1  pixel valid.
- in_pixel  in  PIX_W  pixel data.
- in_ready  out  1  pixel accepted when in_valid&&in_ready.
- rd_oe_nxt  in  1  reader will assert OEB next cycle.
- rd_addr_nxt  in  ADDR_W  port-B address the reader presents next cycle.
- sram_a  out  ADDR_W  port-A address (registered).
- sram_dia  out  LANES*PIX_W  port-A write data (registered).
- sram_wean  out  LANES  active-low lane write enables (registered).
- sram_oea  out  1  port-A output enable; always 0 (write-only port).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the last write is issued.

Behaviour:
- Reset values: in_ready=0, sram_a=0, sram_dia=0, sram_wean='1, sram_oea=0, busy=0, done=0, FSM=IDLE, counters=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches base_addr into waddr, pix_count into remaining, and sets lane=0.
  - If pix_count==0, go to FIN; otherwise go to RUN with busy=1.
- RUN, combinational in_ready = !(rd_oe_nxt && rd_addr_nxt==waddr).
- RUN, on accept (next edge):
  - sram_a<=waddr.
  - sram_dia lane[lane]<=in_pixel; other lanes hold 0.
  - sram_wean<=~(1<<lane).
  - lane advances 0->1->2->0; on 2->0, waddr<=waddr+1, wrapping mod 2^ADDR_W (1023->0).
  - remaining decrements; on the accept where remaining==1, go to FIN.
- RUN, no accept: sram_wean<='1 next cycle, sram_a holds. Write latency is 1 cycle from accept.
- FIN: done=1 and busy=0 for one cycle, sram_wean='1, then IDLE.
- start while RUN/FIN is ignored.
- Collision check uses the address that will be registered, so no write ever coincides with an equal port-B read.
- Async rst mid-job aborts the job: outputs return to reset values immediately and no further writes occur.

Optional Feature:
- Macro: PIXEL_WR_PACK_EN.
- Defined:
  - Pixels collect in a LANES-wide pack register; one write per word with sram_wean=000.
  - The final partial word writes only its filled lanes (e.g. 2 pixels -> wean=100).
  - The collision check applies to the word-issue cycle only; lanes fill without stalls.
  - Latency is 1 cycle from the accept of the word's last pixel.
- Undefined: per-pixel lane writes exactly as in Behaviour.

Test Plan:
- base=0x010, count=7, continuous valid, no reads -> 7 writes:
  - addr 0x010 wean 110,101,011; 0x011 110,101,011; 0x012 110.
  - done pulse on the cycle after the 7th write; busy low afterwards.
- base=0x3FF, count=4 -> 3 lane writes at 0x3FF, 4th at 0x000 lane0; confirms wrap.
- count=0 start -> no wean activity; done one cycle after start; in_ready stays 0.
- rd_oe_nxt=1 with rd_addr_nxt==waddr for 3 cycles mid-job -> in_ready=0 for those 3 cycles, no write issued, resumes with no pixel lost or duplicated.
- rst asserted after 2 of 6 pixels -> outputs reset asynchronously, then a new start with count=3 writes base lanes 0..2 cleanly.
- PIXEL_WR_PACK_EN, count=5, base=0 -> addr 0 wean 000 data {p2,p1,p0}; addr 1 wean 100 data {0,p4,p3}.
